// File: rtl/instr_pingpong_ctrl_pkg.sv
// instr_pingpong_ctrl_pkg: state types and bank constants for the ping/pong instruction sequencer
package instr_pingpong_ctrl_pkg;
  typedef enum logic {L_IDLE, L_WRITE} load_state_t;
  typedef enum logic [1:0] {X_IDLE, X_SWAP, X_RUN, X_DRAIN} exec_state_t;
  localparam logic PING = 1'b0;
  localparam logic PONG = 1'b1;
  localparam int DRAIN_CYC_DEF = 8;
endpackage

// File: rtl/instr_pingpong_ctrl_if.sv
// instr_pingpong_ctrl_if: host load, instruction-memory write and core fetch signals of the sequencer
interface instr_pingpong_ctrl_if #(
  parameter int ADDR_L = 10,
  parameter int INSTR_W = 64,
  parameter int CNT_W = 16
);
  logic host_load_start;
  logic [ADDR_L:0] host_load_len;
  logic host_load_ack;
  logic host_wr_vld;
  logic [INSTR_W-1:0] host_wr_data;
  logic host_wr_rdy;
  logic instr_we;
  logic [ADDR_L-1:0] instr_wr_addr;
  logic [INSTR_W-1:0] instr_wr_data;
  logic io_ping_wr;
  logic enable_execution;
  logic core_rd_vld;
  logic [ADDR_L-1:0] core_rd_addr;
  logic [1:0] bank_full;
  logic [CNT_W-1:0] blk_cnt;
  logic load_err;
  modport slave (
    input host_load_start, host_load_len, host_wr_vld, host_wr_data, core_rd_vld, core_rd_addr,
    output host_load_ack, host_wr_rdy, instr_we, instr_wr_addr, instr_wr_data, io_ping_wr,
    output enable_execution, bank_full, blk_cnt, load_err
  );
  modport master (
    output host_load_start, host_load_len, host_wr_vld, host_wr_data, core_rd_vld, core_rd_addr,
    input host_load_ack, host_wr_rdy, instr_we, instr_wr_addr, instr_wr_data, io_ping_wr,
    input enable_execution, bank_full, blk_cnt, load_err
  );
endinterface

// File: rtl/instr_pingpong_ctrl.sv
// instr_pingpong_ctrl: loads host blocks into the fill bank and swaps/gates execution of the other bank
module instr_pingpong_ctrl
  import instr_pingpong_ctrl_pkg::*;
#(
  parameter int ADDR_L = 10,
  parameter int INSTR_W = 64,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  instr_pingpong_ctrl_if.slave bus
);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [ADDR_L:0] MAX_LEN = {1'b1, {ADDR_L{1'b0}}};
  localparam logic [ADDR_L:0] ONE = (ADDR_L + 1)'(1);
  load_state_t l_q, l_d;
  exec_state_t x_q, x_d;
  logic [1:0][ADDR_L:0] len_q, len_d;
  logic [ADDR_L:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_L-1:0] addr_q, addr_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [1:0] full_q, full_d;
  logic ack_q, ack_d, err_q, err_d, we_q, we_d, ping_q, ping_d, done_q, done_d;
  logic fill, exec, start_ok, wr_hs, wr_last, fetch_last, drain_last;
  always_comb begin
    fill = ping_q ? PING : PONG;
    exec = ~fill;
    wr_hs = (l_q == L_WRITE) && bus.host_wr_vld;
    wr_last = wr_ptr_q == len_q[fill] - ONE;
    // done_q covers the cycle between the last write and bank_full rising
    start_ok = (l_q == L_IDLE) && bus.host_load_start && !full_q[fill] && !done_q &&
               (bus.host_load_len != '0) && (bus.host_load_len <= MAX_LEN);
    fetch_last = (x_q == X_RUN) && bus.core_rd_vld && ({1'b0, bus.core_rd_addr} == len_q[exec] - ONE);
    drain_last = (x_q == X_DRAIN) && (drain_q == DRAIN_LAST);
    l_d = start_ok ? L_WRITE : (wr_hs && wr_last) ? L_IDLE : l_q;
    x_d = (x_q == X_IDLE) ? ((full_q[fill] && l_q == L_IDLE) ? X_SWAP : X_IDLE) :
          (x_q == X_SWAP) ? X_RUN :
          (x_q == X_RUN) ? (fetch_last ? X_DRAIN : X_RUN) :
          (drain_last ? X_IDLE : X_DRAIN);
    len_d = len_q;
    if (start_ok) len_d[fill] = bus.host_load_len;
    full_d = full_q;
    if (done_q) full_d[fill] = 1'b1;
    if (drain_last) full_d[exec] = 1'b0;
    wr_ptr_d = start_ok ? '0 : wr_hs ? wr_ptr_q + ONE : wr_ptr_q;
    addr_d = wr_hs ? wr_ptr_q[ADDR_L-1:0] : addr_q;
    data_d = wr_hs ? bus.host_wr_data : data_q;
    we_d = wr_hs;
    done_d = wr_hs && wr_last;
    ack_d = start_ok;
    err_d = (l_q == L_IDLE) && bus.host_load_start && !start_ok;
    ping_d = (x_q == X_SWAP) ? ~ping_q : ping_q;
    drain_d = (x_q == X_DRAIN) ? drain_q + DW'(1) : '0;
    cnt_d = drain_last ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      l_q <= L_IDLE;
      x_q <= X_IDLE;
      len_q <= '0;
      wr_ptr_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      drain_q <= '0;
      full_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      we_q <= 1'b0;
      ping_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      l_q <= l_d;
      x_q <= x_d;
      len_q <= len_d;
      wr_ptr_q <= wr_ptr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      drain_q <= drain_d;
      full_q <= full_d;
      ack_q <= ack_d;
      err_q <= err_d;
      we_q <= we_d;
      ping_q <= ping_d;
      done_q <= done_d;
    end
  end
  assign bus.host_load_ack = ack_q;
  assign bus.load_err = err_q;
  assign bus.host_wr_rdy = l_q == L_WRITE;
  assign bus.instr_we = we_q;
  assign bus.instr_wr_addr = addr_q;
  assign bus.instr_wr_data = data_q;
  assign bus.io_ping_wr = ping_q;
  assign bus.enable_execution = x_q == X_RUN;
  assign bus.bank_full = full_q;
  assign bus.blk_cnt = cnt_q;
endmodule

// File: tb/tb_instr_pingpong_ctrl.sv
// tb_instr_pingpong_ctrl: vector table, directed block sequences and randomized pipelined blocks vs a transaction model
module tb_instr_pingpong_ctrl;
  localparam int AL = 10;
  localparam int IW = 64;
  localparam int CW = 16;
  localparam int DRAIN = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  instr_pingpong_ctrl_if #(.ADDR_L(AL), .INSTR_W(IW), .CNT_W(CW)) bus ();
  instr_pingpong_ctrl #(.ADDR_L(AL), .INSTR_W(IW), .DRAIN_CYC(DRAIN), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct {
    logic [AL-1:0] addr;
    logic [IW-1:0] data;
    logic ping;
  } wr_t;
  typedef struct packed {
    logic [AL:0] len;
    logic ack;
    logic err;
  } vec_t;
  wr_t wq[$];
  wr_t we_exp;
  int lq[$];
  int n_chk = 0;
  int n_fail = 0;
  logic m_ping = 1'b1;
  logic [CW-1:0] m_cnt = '0;
  vec_t vt[5];
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // every write strobe must match the next expected (addr, data, fill bank) in order
  always @(negedge clk) begin
    if (!rst && bus.instr_we) begin
      chk("we_expected", 64'(wq.size() != 0), 1);
      if (wq.size() != 0) begin
        we_exp = wq.pop_front();
        chk("wr_addr", 64'(bus.instr_wr_addr), 64'(we_exp.addr));
        chk("wr_data", bus.instr_wr_data, we_exp.data);
        chk("wr_bank", 64'(bus.io_ping_wr), 64'(we_exp.ping));
      end
    end
  end
  task automatic clr_in;
    bus.host_load_start = 1'b0;
    bus.host_load_len = '0;
    bus.host_wr_vld = 1'b0;
    bus.host_wr_data = '0;
    bus.core_rd_vld = 1'b0;
    bus.core_rd_addr = '0;
  endtask
  task automatic model_reset;
    m_ping = 1'b1;
    m_cnt = '0;
    wq.delete();
    lq.delete();
  endtask
  task automatic do_reset;
    clr_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
  endtask
  task automatic check_rst;
    chk("rst_ctrl", 64'({bus.host_load_ack, bus.host_wr_rdy, bus.instr_we, bus.io_ping_wr,
                        bus.enable_execution, bus.load_err}), 64'b000100);
    chk("rst_full", 64'(bus.bank_full), 0);
    chk("rst_cnt", 64'(bus.blk_cnt), 0);
    chk("rst_addr", 64'(bus.instr_wr_addr), 0);
    chk("rst_data", bus.instr_wr_data, 0);
  endtask
  task automatic load_block(input int len, input logic [IW-1:0] base, input int gap, input bit noise);
    logic fb;
    fb = m_ping;
    for (int i = 0; i < len; i++) wq.push_back('{addr: AL'(i), data: base + IW'(i), ping: fb});
    lq.push_back(len);
    bus.host_load_start = 1'b1;
    bus.host_load_len = (AL + 1)'(len);
    step();
    bus.host_load_start = noise;
    chk("load_ack", 64'(bus.host_load_ack), 1);
    chk("load_rdy", 64'(bus.host_wr_rdy), 1);
    for (int i = 0; i < len; i++) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        bus.host_wr_vld = 1'b0;
        step();
      end
      bus.host_wr_vld = 1'b1;
      bus.host_wr_data = base + IW'(i);
      if (i == len - 1) bus.host_load_start = 1'b0;
      step();
      chk("no_ack_err", 64'({bus.host_load_ack, bus.load_err}), 0);
    end
    bus.host_wr_vld = 1'b0;
    chk("rdy_drop", 64'(bus.host_wr_rdy), 0);
    step();
    chk("full_set", 64'(bus.bank_full[fb ? 0 : 1]), 1);
  endtask
  task automatic reject(input int len);
    bus.host_load_start = 1'b1;
    bus.host_load_len = (AL + 1)'(len);
    step();
    bus.host_load_start = 1'b0;
    chk("rej_err", 64'(bus.load_err), 1);
    chk("rej_ack", 64'(bus.host_load_ack), 0);
    chk("rej_rdy", 64'(bus.host_wr_rdy), 0);
    step();
    chk("rej_pulse", 64'(bus.load_err), 0);
  endtask
  task automatic wait_run(input int exp_wait, output int len);
    int n;
    n = 0;
    while (!bus.enable_execution && n < 3000) begin
      step();
      n++;
    end
    chk("run_start", 64'(bus.enable_execution), 1);
    if (exp_wait >= 0) chk("swap_gap", 64'(n), 64'(exp_wait));
    chk("swap_ping", 64'(bus.io_ping_wr), 64'(!m_ping));
    m_ping = !m_ping;
    chk("exec_full", 64'(bus.bank_full[m_ping ? 1 : 0]), 1);
    len = (lq.size() != 0) ? lq.pop_front() : 1;
  endtask
  task automatic fetch_block(input int len, input bit junk);
    int eb;
    logic [AL-1:0] ja;
    eb = m_ping ? 1 : 0;
    for (int a = 0; a < len; a++) begin
      if (junk && $urandom_range(0, 2) == 0) begin
        ja = AL'($urandom);
        if (ja == AL'(len - 1)) ja = ja + 1'b1;
        bus.core_rd_vld = 1'($urandom_range(0, 1));
        bus.core_rd_addr = ja;
        step();
        chk("en_hold", 64'(bus.enable_execution), 1);
      end
      bus.core_rd_vld = 1'b1;
      bus.core_rd_addr = AL'(a);
      step();
      bus.core_rd_vld = 1'b0;
      chk(a == len - 1 ? "en_drop" : "en_run", 64'(bus.enable_execution), 64'(a != len - 1));
    end
    repeat (DRAIN - 1) step();
    chk("drain_full", 64'(bus.bank_full[eb]), 1);
    chk("drain_cnt", 64'(bus.blk_cnt), 64'(m_cnt));
    step();
    chk("retire_full", 64'(bus.bank_full[eb]), 0);
    m_cnt = m_cnt + 1'b1;
    chk("blk_cnt", 64'(bus.blk_cnt), 64'(m_cnt));
    chk("drain_en", 64'(bus.enable_execution), 0);
  endtask
  initial begin
    int len;
    int nl;
    vt[0] = '{len: 0, ack: 0, err: 1};
    vt[1] = '{len: 1, ack: 1, err: 0};
    vt[2] = '{len: 1024, ack: 1, err: 0};
    vt[3] = '{len: 1025, ack: 0, err: 1};
    vt[4] = '{len: 2047, ack: 0, err: 1};
    clr_in();
    for (int v = 0; v < 5; v++) begin
      do_reset();
      if (v == 0) check_rst();
      bus.host_load_start = 1'b1;
      bus.host_load_len = vt[v].len;
      step();
      bus.host_load_start = 1'b0;
      chk("vec_ack", 64'(bus.host_load_ack), 64'(vt[v].ack));
      chk("vec_err", 64'(bus.load_err), 64'(vt[v].err));
      chk("vec_rdy", 64'(bus.host_wr_rdy), 64'(vt[v].ack));
    end
    do_reset();
    check_rst();
    load_block(4, 64'hA0, 0, 0);
    chk("t1_full", 64'(bus.bank_full), 64'b01);
    chk("t1_en", 64'(bus.enable_execution), 0);
    wait_run(2, len);
    chk("t1_ping", 64'(bus.io_ping_wr), 0);
    fetch_block(len, 0);
    load_block(4, 64'hB0, 0, 0);
    wait_run(2, len);
    fork
      fetch_block(len, 0);
      begin
        load_block(3, 64'hC0, 0, 0);
        reject(5);
      end
    join
    wait_run(2, len);
    chk("t3_ping", 64'(bus.io_ping_wr), 0);
    fetch_block(len, 1);
    load_block(1024, {$urandom, $urandom}, 0, 1);
    chk("t5_last_addr", 64'(bus.instr_wr_addr), 1023);
    wait_run(2, len);
    fetch_block(len, 0);
    load_block(4, 64'hD0, 0, 0);
    wait_run(2, len);
    for (int a = 0; a < 2; a++) begin
      bus.core_rd_vld = 1'b1;
      bus.core_rd_addr = AL'(a);
      step();
    end
    bus.core_rd_addr = AL'(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clr_in();
    check_rst();
    model_reset();
    load_block(2, 64'hE0, 0, 0);
    wait_run(2, len);
    fetch_block(len, 0);
    load_block($urandom_range(1, 12), {$urandom, $urandom}, 40, 0);
    for (int k = 0; k < 10; k++) begin
      wait_run(-1, len);
      nl = $urandom_range(1, 12);
      fork
        fetch_block(len, 1);
        begin
          if (k < 9) load_block(nl, {$urandom, $urandom}, 40, 0);
        end
      join
    end
    step();
    chk("wq_empty", 64'(wq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
